fetch_pc_unit: RTL

Instruction-fetch and program-counter block for the single-cycle RISC-V core. It owns the architectural PC and fetches instructions over a single-outstanding request/response interface to instruction memory. It presents each instruction to the core through a valid/ready handshake and accepts taken-branch/jump redirects from the core's next-PC logic. Its `PC` output is the value the ALU operand-A mux selects when `ALUASrc = 1`.

---
 rtl/fetch_pc_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: architectural PC plus single-outstanding instruction fetch
// with a valid/ready hand-off to the core and redirect support.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (trap on misaligned redirect).
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PCplus4,
    output logic [31:0] Inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misaligned
`endif
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST    = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_P4 = RESET_PC + XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        S_TRAP  = 2'd3
`endif
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   fetch_pc_nxt;
    logic              discard;
    logic              discard_nxt;
    logic              capture;
    logic              req_c;
    logic [XLEN-1:0]   target_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic              trap_set;
`endif

    // Low address bits of a redirect target are dropped; misaligned targets trap when checking is enabled.
    assign target_pc = redirect_pc & ALIGN_MASK;
    assign imem_addr = fetch_pc;
    assign imem_req  = req_c & ~rst;

    // State, fetch PC and discard-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            discard  <= discard_nxt;
        end
    end

    // Next-state, next fetch PC and request decode; redirect wins over every other event.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        discard_nxt  = discard;
        capture      = 1'b0;
        req_c        = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        trap_set     = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                if (redirect) begin
                    fetch_pc_nxt = target_pc;
                end else begin
                    req_c     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_nxt = target_pc;
                    if (imem_rvalid) begin
                        discard_nxt = 1'b0;
                        state_nxt   = S_FETCH;
                    end else begin
                        discard_nxt = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (discard) begin
                        discard_nxt = 1'b0;
                        state_nxt   = S_FETCH;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = S_VALID;
                    end
                end
            end
            S_VALID: begin
                if (redirect) begin
                    fetch_pc_nxt = target_pc;
                    state_nxt    = S_FETCH;
                end else if (inst_ready) begin
                    fetch_pc_nxt = fetch_pc + XLEN'(4);
                    state_nxt    = S_FETCH;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
`endif
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect && (redirect_pc[1:0] != 2'b00) && (state != S_TRAP)) begin
            state_nxt    = S_TRAP;
            fetch_pc_nxt = fetch_pc;
            discard_nxt  = 1'b0;
            capture      = 1'b0;
            req_c        = 1'b0;
            trap_set     = 1'b1;
        end
`endif
    end

    // Presented instruction, its PC, and the valid / sticky-trap flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC         <= RESET_PC;
            PCplus4    <= RESET_PC_P4;
            Inst       <= NOP_INST;
            inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned <= 1'b0;
`endif
        end else begin
            inst_valid <= (state_nxt == S_VALID);
            if (capture) begin
                Inst    <= imem_rdata;
                PC      <= fetch_pc;
                PCplus4 <= fetch_pc + XLEN'(4);
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            if (trap_set) begin
                misaligned <= 1'b1;
            end
`endif
        end
    end

endmodule
